// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-to-memory bus bridge.
// The optional posted-write behaviour is selected in the bridge with MEM_BRIDGE_WPOST_EN.
package mem_bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;

   // Returned to the CPU when memory never answers, so a stalled fetch decodes as a harmless NOP
   localparam logic [BUS_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } bridge_state_e;

   typedef struct packed {
      logic                  we;
      logic                  sel;
      logic [BUS_ADDR_W-1:0] adr;
      logic [BUS_DATA_W-1:0] wdata;
   } mem_req_t;

   // Split a CPU address into {region flag, memory address}; the region bit is cleared in the address
   function automatic logic [BUS_ADDR_W:0] decode_addr(input logic [BUS_ADDR_W-1:0] adr);
      return {adr[BUS_ADDR_W-1], 1'b0, adr[BUS_ADDR_W-2:0]};
   endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Wait-cycle counter for the bus bridge.
// Counts enabled cycles after a clear and flags the cycle in which the limit is reached.
module bridge_timeout_ctr #(
   parameter int LIMIT = 255,
   parameter int W     = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic at_limit
);

   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] count;

   // Count enabled cycles, restarting on clear and holding once the limit cycle is reached
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && !at_limit) begin
         count <= count + W'(1);
      end
   end

   assign at_limit = (count == LAST);

endmodule

// File: rtl/mem_bus_bridge.sv
// CPU memory port to valid/ready memory bridge.
// Turns single-cycle CPU read/write enables into a registered request/response
// transaction, stalls the CPU through cpu_ready, and raises a sticky bus_err
// when memory does not answer within TMO_CYC wait cycles.
// Build option MEM_BRIDGE_WPOST_EN: writes are posted (CPU released one cycle
// after capture, the memory transaction finishes in the background).
module mem_bus_bridge
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TMO_CYC = 255,
   parameter int TMO_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_rd_en,
   input  logic              cpu_wr_en,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic              mem_req_sel,
   output logic [ADDR_W-1:0] mem_req_adr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata,
   output logic              bus_err
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_REQ  = REQ;
   localparam logic [1:0] ST_WAIT = WAIT;
   localparam logic [1:0] ST_RESP = RESP;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [1:0]        wait_exit;
   mem_req_t          req;
   logic [DATA_W-1:0] rdata_q;
   logic              bus_err_q;
   logic              capture;
   logic              in_wait;
   logic              tmo_at_limit;

   assign capture = (state == ST_IDLE) && (cpu_rd_en || cpu_wr_en);
   assign in_wait = (state == ST_WAIT);

   bridge_timeout_ctr #(
      .LIMIT(TMO_CYC),
      .W    (TMO_W)
   ) u_tmo (
      .clk     (clk),
      .reset   (reset),
      .clear   (!in_wait),
      .en      (in_wait && !mem_rsp_valid),
      .at_limit(tmo_at_limit)
   );

`ifdef MEM_BRIDGE_WPOST_EN
   logic post_ack;

   // A posted write has already released the CPU, so its completion returns straight to IDLE
   assign wait_exit = req.we ? ST_IDLE : ST_RESP;

   // One-cycle early acknowledge to the CPU for every captured write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         post_ack <= 1'b0;
      end else begin
         post_ack <= capture && cpu_wr_en;
      end
   end

   assign cpu_ready = (state == ST_RESP) || post_ack;
`else
   assign wait_exit = ST_RESP;
   assign cpu_ready = (state == ST_RESP);
`endif

   // Next-state decode: a response or an expired wait both leave WAIT
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (cpu_rd_en || cpu_wr_en) state_nxt = ST_REQ;
         ST_REQ:  if (mem_req_ready) state_nxt = ST_WAIT;
         ST_WAIT: if (mem_rsp_valid || tmo_at_limit) state_nxt = wait_exit;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register; reset drops any transaction in flight at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the CPU request only in IDLE so later CPU activity cannot disturb the bus
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req <= '0;
      end else if (capture) begin
         req.we             <= cpu_wr_en;
         {req.sel, req.adr} <= decode_addr(cpu_adr);
         req.wdata          <= cpu_wdata;
      end
   end

   // Latch the read data (zero for writes) or the NOP fallback and sticky error on timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
      end else if (in_wait) begin
         if (mem_rsp_valid) begin
            rdata_q <= req.we ? '0 : mem_rsp_rdata;
         end else if (tmo_at_limit) begin
            rdata_q   <= NOP_INSTR;
            bus_err_q <= 1'b1;
         end
      end
   end

   assign mem_req_valid = (state == ST_REQ);
   assign mem_req_we    = req.we;
   assign mem_req_sel   = req.sel;
   assign mem_req_adr   = req.adr;
   assign mem_req_wdata = req.wdata;
   assign cpu_rdata     = rdata_q;
   assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard testbench for mem_bus_bridge.
// Stimulus pushes expected requests/responses into queues; monitors pop and compare
// whenever the bridge hands a request to memory or releases the CPU.
`timescale 1ns/1ps
module tb_mem_bus_bridge;

`ifdef MEM_BRIDGE_WPOST_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] cpu_adr;
   logic [31:0] cpu_wdata;
   logic        cpu_rd_en;
   logic        cpu_wr_en;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic        mem_req_sel;
   logic [31:0] mem_req_adr;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        bus_err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      bit          chk_data;
      int          lat;
      int          issue;
      string       name;
   } exp_rsp_t;

   typedef struct {
      logic        we;
      logic        sel;
      logic [31:0] adr;
      logic [31:0] wdata;
      int          stall;
      string       name;
   } exp_req_t;

   exp_rsp_t    rsp_q[$];
   exp_req_t    req_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          ready_pulses = 0;
   int          ready_delay = 0;
   int          rsp_gap = 0;
   logic [31:0] rsp_data = '0;

   mem_bus_bridge #(
      .ADDR_W (32),
      .DATA_W (32),
      .TMO_CYC(4),
      .TMO_W  (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_adr      (cpu_adr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rd_en    (cpu_rd_en),
      .cpu_wr_en    (cpu_wr_en),
      .cpu_rdata    (cpu_rdata),
      .cpu_ready    (cpu_ready),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_we   (mem_req_we),
      .mem_req_sel  (mem_req_sel),
      .mem_req_adr  (mem_req_adr),
      .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_rdata(mem_rsp_rdata),
      .bus_err      (bus_err)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle number used for latency measurements
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [95:0] actual, input logic [95:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Memory model: accepts after ready_delay stalled cycles, answers rsp_gap cycles after the
   // earliest legal response cycle (negative gap = never answers)
   initial begin
      int vcnt;
      int cd;
      vcnt = 0;
      cd = -1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      forever begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         if (cd == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rsp_data;
            cd = -1;
         end else if (cd > 0) begin
            cd--;
         end
         if (mem_req_valid) begin
            if (vcnt >= ready_delay) begin
               mem_req_ready = 1'b1;
               cd = rsp_gap;
               vcnt = 0;
            end else begin
               mem_req_ready = 1'b0;
               vcnt++;
            end
         end else begin
            mem_req_ready = 1'b0;
            vcnt = 0;
         end
      end
   end

   // Request-side monitor: payload stability under backpressure and per-handshake comparison
   initial begin
      bit          stalled;
      logic [65:0] held;
      int          stall_cnt;
      exp_req_t    e;
      stalled = 1'b0;
      held = '0;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            stalled = 1'b0;
            stall_cnt = 0;
         end else if (mem_req_valid) begin
            if (stalled)
               check_output("req_payload_stable", 96'({mem_req_we, mem_req_sel, mem_req_adr, mem_req_wdata}), 96'(held));
            if (mem_req_ready) begin
               if (req_q.size() == 0) begin
                  check_output("req_unexpected", 96'(1), 96'(0));
               end else begin
                  e = req_q.pop_front();
                  check_output({e.name, "_req_we"}, 96'(mem_req_we), 96'(e.we));
                  check_output({e.name, "_req_sel"}, 96'(mem_req_sel), 96'(e.sel));
                  check_output({e.name, "_req_adr"}, 96'(mem_req_adr), 96'(e.adr));
                  check_output({e.name, "_req_wdata"}, 96'(mem_req_wdata), 96'(e.wdata));
                  check_output({e.name, "_req_stall"}, 96'(stall_cnt), 96'(e.stall));
               end
               stalled = 1'b0;
               stall_cnt = 0;
            end else begin
               stalled = 1'b1;
               stall_cnt++;
               held = {mem_req_we, mem_req_sel, mem_req_adr, mem_req_wdata};
            end
         end else begin
            if (stalled) check_output("req_valid_held", 96'(0), 96'(1));
            stalled = 1'b0;
            stall_cnt = 0;
         end
      end
   end

   // CPU-side monitor: every cpu_ready pulse must match the oldest expected response
   initial begin
      exp_rsp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (reset && cpu_ready) begin
            ready_pulses++;
            if (rsp_q.size() == 0) begin
               check_output("rsp_unexpected", 96'(1), 96'(0));
            end else begin
               e = rsp_q.pop_front();
               if (e.chk_data) check_output({e.name, "_rdata"}, 96'(cpu_rdata), 96'(e.rdata));
               check_output({e.name, "_bus_err"}, 96'(bus_err), 96'(e.err));
               if (e.lat >= 0) check_output({e.name, "_latency"}, 96'(cyc - e.issue), 96'(e.lat));
            end
         end
      end
   end

   // One CPU access: queue expectations, hold the enables until cpu_ready (bounded), then release
   task automatic apply_stimulus(
      input string name, input bit sync, input bit wr, input bit rd,
      input logic [31:0] adr, input logic [31:0] wdata,
      input int rdy_dly, input int gap, input logic [31:0] mem_data,
      input bit exp_we, input bit exp_sel, input logic [31:0] exp_adr,
      input logic [31:0] exp_rdata, input bit exp_err, input bit chk_data,
      input int exp_lat, input int exp_stall);
      exp_rsp_t r;
      exp_req_t q;
      bit       seen;
      if (sync) @(negedge clk);
      ready_delay = rdy_dly;
      rsp_gap = gap;
      rsp_data = mem_data;
      q.we = exp_we;
      q.sel = exp_sel;
      q.adr = exp_adr;
      q.wdata = wdata;
      q.stall = exp_stall;
      q.name = name;
      req_q.push_back(q);
      r.rdata = exp_rdata;
      r.err = exp_err;
      r.chk_data = chk_data;
      r.lat = exp_lat;
      r.issue = cyc;
      r.name = name;
      rsp_q.push_back(r);
      cpu_adr = adr;
      cpu_wdata = wdata;
      cpu_wr_en = wr;
      cpu_rd_en = rd;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (cpu_ready) seen = 1'b1;
      end
      cpu_wr_en = 1'b0;
      cpu_rd_en = 1'b0;
      if (!seen) check_output({name, "_ready_timeout"}, 96'(0), 96'(1));
   endtask

   // Hard stop in case the sequence itself gets stuck
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      exp_req_t q;
      int       pulses_before;
      reset = 1'b1;
      cpu_adr = '0;
      cpu_wdata = '0;
      cpu_rd_en = 1'b0;
      cpu_wr_en = 1'b0;
      #1 reset = 1'b0;
      idle(2);
      #2;
      check_output("rst_cpu_ready", 96'(cpu_ready), 96'(0));
      check_output("rst_req_valid", 96'(mem_req_valid), 96'(0));
      check_output("rst_bus_err", 96'(bus_err), 96'(0));
      check_output("rst_cpu_rdata", 96'(cpu_rdata), 96'(0));
      check_output("rst_req_payload", 96'({mem_req_we, mem_req_sel, mem_req_adr, mem_req_wdata}), 96'(0));
      #1 reset = 1'b1;
      idle(3);

      apply_stimulus("rd_instant", 1, 0, 1, 32'h0000_0010, 32'h0, 0, 0, 32'h1234_5678,
                     0, 0, 32'h0000_0010, 32'h1234_5678, 0, 1, 3, 0);
      idle(10);
      apply_stimulus("wr_data", 1, 1, 0, 32'h8000_0040, 32'hCAFE_F00D, 2, 1, 32'hFFFF_FFFF,
                     1, 1, 32'h0000_0040, 32'h0, 0, !POSTED, POSTED ? 1 : 6, 2);
      idle(10);
      apply_stimulus("rd_backpressure", 1, 0, 1, 32'h8000_0020, 32'h0, 5, 0, 32'hDEAD_BEEF,
                     0, 1, 32'h0000_0020, 32'hDEAD_BEEF, 0, 1, 8, 5);
      idle(10);
      apply_stimulus("rdwr_both", 1, 1, 1, 32'h0000_0100, 32'h1111_2222, 0, 0, 32'h5555_5555,
                     1, 0, 32'h0000_0100, 32'h0, 0, !POSTED, POSTED ? 1 : 3, 0);
      idle(10);
      apply_stimulus("timeout", 1, 0, 1, 32'h0000_0200, 32'h0, 0, -1, 32'h0,
                     0, 0, 32'h0000_0200, 32'h0000_0013, 1, 1, 6, 0);
      idle(3);
      check_output("bus_err_sticky", 96'(bus_err), 96'(1));
      apply_stimulus("rd_after_tmo", 1, 0, 1, 32'h0000_0004, 32'h0, 0, 0, 32'hA5A5_A5A5,
                     0, 0, 32'h0000_0004, 32'hA5A5_A5A5, 1, 1, 3, 0);
      idle(10);

      // Reset while the bridge waits for a response that arrives only after reset is released
      @(negedge clk);
      ready_delay = 0;
      rsp_gap = 3;
      rsp_data = 32'h7777_7777;
      q.we = 1'b0;
      q.sel = 1'b1;
      q.adr = 32'h0000_0030;
      q.wdata = 32'h0;
      q.stall = 0;
      q.name = "rst_wait";
      req_q.push_back(q);
      cpu_adr = 32'h8000_0030;
      cpu_wdata = 32'h0;
      cpu_rd_en = 1'b1;
      @(negedge clk);
      cpu_rd_en = 1'b0;
      @(negedge clk);
      #3 reset = 1'b0;
      #1;
      check_output("rstw_cpu_ready", 96'(cpu_ready), 96'(0));
      check_output("rstw_req_valid", 96'(mem_req_valid), 96'(0));
      check_output("rstw_bus_err", 96'(bus_err), 96'(0));
      check_output("rstw_cpu_rdata", 96'(cpu_rdata), 96'(0));
      check_output("rstw_req_payload", 96'({mem_req_we, mem_req_sel, mem_req_adr, mem_req_wdata}), 96'(0));
      pulses_before = ready_pulses;
      @(negedge clk);
      #3 reset = 1'b1;
      idle(6);
      check_output("late_rsp_ignored", 96'(ready_pulses - pulses_before), 96'(0));
      check_output("late_rsp_req_valid", 96'(mem_req_valid), 96'(0));

      apply_stimulus("rd_post_reset", 1, 0, 1, 32'h8000_0008, 32'h0, 0, 0, 32'h0F0F_0F0F,
                     0, 1, 32'h0000_0008, 32'h0F0F_0F0F, 0, 1, 3, 0);
      idle(10);

`ifdef MEM_BRIDGE_WPOST_EN
      // Posted write released after one cycle; the read must wait for the write's ack
      apply_stimulus("post_wr", 1, 1, 0, 32'h8000_0050, 32'hBEEF_0001, 0, 2, 32'h0,
                     1, 1, 32'h0000_0050, 32'h0, 0, 0, 1, 0);
      apply_stimulus("post_rd", 0, 0, 1, 32'h0000_0060, 32'h0, 0, 2, 32'h2468_ACE0,
                     0, 0, 32'h0000_0060, 32'h2468_ACE0, 0, 1, 9, 0);
      idle(10);
`endif

      idle(5);
      check_output("rsp_queue_empty", 96'(rsp_q.size()), 96'(0));
      check_output("req_queue_empty", 96'(req_q.size()), 96'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
